// File: rtl/fir_coef_loader.sv
// -----------------------------------------------------------------------------
// fir_coef_loader
//
// Double-buffered coefficient bank for the 37-tap FIR datapath. Writes arrive
// on a valid/ready port and land in a shadow bank. A commit copies the whole
// shadow bank into the active bank in a single edge, so the FIR never sees a
// partially updated tap set. Both banks come out of reset holding an impulse
// (centre tap at full positive scale), which makes the FIR a pure delay.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   wr_valid     coefficient write request
//   wr_ready     write can be accepted this cycle (low only while swapping)
//   wr_addr      tap index of the write
//   wr_data      signed coefficient value
//   commit       request a shadow->active copy
//   commit_done  one-cycle pulse, active bank has just been updated
//   addr_err     one-cycle pulse, last accepted write had an illegal address
//   wr_count     accepted writes since the last commit (saturating)
//   taps_flat    active bank, tap k at bits [k*WL +: WL]
//
// ADDR_WL must be wide enough to index every tap (2**ADDR_WL >= TAP_NUM).
// -----------------------------------------------------------------------------
module fir_coef_loader #(
   parameter int WL      = 14,
   parameter int TAP_NUM = 37,
   parameter int ADDR_WL = 6,
   parameter int SYM     = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [ADDR_WL-1:0]        wr_addr,
   input  logic signed [WL-1:0]      wr_data,
   input  logic                      commit,
   output logic                      commit_done,
   output logic                      addr_err,
   output logic [ADDR_WL:0]          wr_count,
   output logic [TAP_NUM*WL-1:0]     taps_flat
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SWAP = 2'd2;

   localparam int CENTRE = (TAP_NUM - 1) / 2;

   // In symmetric mode only the lower half (centre included) is addressable;
   // the upper half is filled by mirroring.
   localparam logic [ADDR_WL:0] ADDR_LIMIT =
      (ADDR_WL+1)'((SYM != 0) ? (CENTRE + 1) : TAP_NUM);

   localparam logic [ADDR_WL:0] COUNT_MAX = '1;

   // Reset image of a single tap: impulse at the centre tap.
   function automatic logic signed [WL-1:0] reset_tap(input int k);
      logic signed [WL-1:0] v;
      v = '0;
      if (k == CENTRE) begin
         v = {1'b0, {(WL-1){1'b1}}};
      end
      return v;
   endfunction

   // Write counter increment that holds at its maximum instead of wrapping.
   function automatic logic [ADDR_WL:0] count_sat_inc(input logic [ADDR_WL:0] c);
      logic [ADDR_WL:0] r;
      r = c;
      if (c != COUNT_MAX) begin
         r = c + 1'b1;
      end
      return r;
   endfunction

   logic [1:0]                 state;
   logic [1:0]                 next_state;
   logic                       accept;
   logic                       legal;
   logic [TAP_NUM-1:0]         hit;
   logic signed [WL-1:0]       shadow [TAP_NUM];
   logic signed [WL-1:0]       active [TAP_NUM];

   assign wr_ready = (state != ST_SWAP);
   assign accept   = wr_valid && wr_ready;
   assign legal    = ({1'b0, wr_addr} < ADDR_LIMIT);

   // Per-tap write enables. In symmetric mode a legal address k also selects
   // TAP_NUM-1-k; for the centre tap both terms pick the same entry.
   always_comb begin
      hit = '0;
      for (int k = 0; k < TAP_NUM; k++) begin
         hit[k] = accept && legal &&
                  ((wr_addr == ADDR_WL'(k)) ||
                   ((SYM != 0) && (wr_addr == ADDR_WL'(TAP_NUM - 1 - k))));
      end
   end

   // A commit wins over a write in IDLE: the write still lands in the shadow
   // bank on the same edge, so it is included in the swap.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (commit) begin
               next_state = ST_SWAP;
            end else if (accept && legal) begin
               next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (commit) begin
               next_state = ST_SWAP;
            end
         end
         ST_SWAP: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Control registers: state, status pulses and write counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         commit_done <= 1'b0;
         addr_err    <= 1'b0;
         wr_count    <= '0;
      end else begin
         state       <= next_state;
         commit_done <= (state == ST_SWAP);
         addr_err    <= accept && !legal;
         if (state == ST_SWAP) begin
            wr_count <= '0;
         end else if (accept) begin
            wr_count <= count_sat_inc(wr_count);
         end
      end
   end

   // Shadow bank: written directly from the write port. Not cleared by a
   // commit, so later loads only need to rewrite the taps that change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAP_NUM; k++) begin
            shadow[k] <= reset_tap(k);
         end
      end else begin
         for (int k = 0; k < TAP_NUM; k++) begin
            if (hit[k]) begin
               shadow[k] <= wr_data;
            end
         end
      end
   end

   // Active bank: whole-bank copy on the single SWAP cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAP_NUM; k++) begin
            active[k] <= reset_tap(k);
         end
      end else if (state == ST_SWAP) begin
         for (int k = 0; k < TAP_NUM; k++) begin
            active[k] <= shadow[k];
         end
      end
   end

   for (genvar k = 0; k < TAP_NUM; k++) begin : g_flat
      assign taps_flat[k*WL +: WL] = active[k];
   end

endmodule

// File: tb/tb_fir_coef_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coef_loader
//
// Directed bench for fir_coef_loader. One instance uses the default
// (asymmetric) addressing, a second instance runs with SYM=1.
// -----------------------------------------------------------------------------
module tb_fir_coef_loader;

   localparam int WL = 14;
   localparam int TN = 37;
   localparam int AW = 6;

   typedef struct {
      int valid;
      int addr;
      int data;
      int commit;
      int ready;
      int err;
      int done;
      int count;
      int tap;
      int tap_val;
   } vec_t;

   logic                  clk = 1'b0;
   logic                  rst_n;

   logic                  wr_valid;
   logic [AW-1:0]         wr_addr;
   logic signed [WL-1:0]  wr_data;
   logic                  commit;
   logic                  wr_ready;
   logic                  commit_done;
   logic                  addr_err;
   logic [AW:0]           wr_count;
   logic [TN*WL-1:0]      taps_flat;

   logic                  s_wr_valid;
   logic [AW-1:0]         s_wr_addr;
   logic signed [WL-1:0]  s_wr_data;
   logic                  s_commit;
   logic                  s_wr_ready;
   logic                  s_commit_done;
   logic                  s_addr_err;
   logic [AW:0]           s_wr_count;
   logic [TN*WL-1:0]      s_taps_flat;

   int n_vec = 0;
   int n_err = 0;

   int half [19] = '{-19, -68, 0, 120, 166, -40, -250, -166, 200, 480,
                     150, -500, -900, -200, 1200, 2500, 3600, 4300, 4600};
   int cf   [TN];
   int imp  [TN];
   int act_m[TN];
   int s_m  [TN];
   vec_t tbl[13];

   fir_coef_loader #(.WL(WL), .TAP_NUM(TN), .ADDR_WL(AW), .SYM(0)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
      .commit_done(commit_done), .addr_err(addr_err), .wr_count(wr_count),
      .taps_flat(taps_flat)
   );

   fir_coef_loader #(.WL(WL), .TAP_NUM(TN), .ADDR_WL(AW), .SYM(1)) dut_sym (
      .clk(clk), .rst_n(rst_n), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready),
      .wr_addr(s_wr_addr), .wr_data(s_wr_data), .commit(s_commit),
      .commit_done(s_commit_done), .addr_err(s_addr_err), .wr_count(s_wr_count),
      .taps_flat(s_taps_flat)
   );

   always #5 clk = ~clk;

   function automatic int tap_of(input logic [TN*WL-1:0] f, input int k);
      logic signed [WL-1:0] t;
      t = f[k*WL +: WL];
      return int'(t);
   endfunction

   function automatic logic [TN*WL-1:0] pack(input int a[TN]);
      logic [TN*WL-1:0] f;
      f = '0;
      for (int k = 0; k < TN; k++) begin
         f[k*WL +: WL] = WL'(a[k]);
      end
      return f;
   endfunction

   task automatic chk_int(input string nm, input integer act, input integer exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_flat(input string nm, input logic [TN*WL-1:0] act,
                           input logic [TN*WL-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int found;

      for (int k = 0; k < 19; k++) begin
         cf[k]      = half[k];
         cf[TN-1-k] = half[k];
      end
      for (int k = 0; k < TN; k++) begin
         imp[k] = (k == 18) ? 8191 : 0;
      end

      // Per-cycle vectors; the block is in LOAD with tap5=-166 pending.
      tbl[0]  = '{1, 40,   123, 0,  1, 1, 0, 2,  5,   -40};
      tbl[1]  = '{0,  0,     0, 0,  1, 0, 0, 2,  5,   -40};
      tbl[2]  = '{0,  0,     0, 1,  0, 0, 0, 2,  5,   -40};
      tbl[3]  = '{0,  0,     0, 0,  1, 0, 1, 0,  5,  -166};
      tbl[4]  = '{0,  0,     0, 0,  1, 0, 0, 0,  5,  -166};
      tbl[5]  = '{0,  0,     0, 1,  0, 0, 0, 0,  5,  -166};
      tbl[6]  = '{0,  0,     0, 1,  1, 0, 1, 0,  5,  -166};
      tbl[7]  = '{0,  0,     0, 0,  1, 0, 0, 0,  5,  -166};
      tbl[8]  = '{1, 36, -8192, 0,  1, 0, 0, 1, 36,   -19};
      tbl[9]  = '{1, 37,   777, 0,  1, 1, 0, 2, 36,   -19};
      tbl[10] = '{0,  0,     0, 1,  0, 0, 0, 2, 36,   -19};
      tbl[11] = '{0,  0,     0, 0,  1, 0, 1, 0, 36, -8192};
      tbl[12] = '{0,  0,     0, 0,  1, 0, 0, 0, 36, -8192};

      rst_n = 1'b0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
      s_wr_valid = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_commit = 1'b0;

      // ---------------- reset ----------------
      repeat (3) @(posedge clk);
      #1;
      chk_flat("rst taps", taps_flat, pack(imp));
      chk_int("rst ready", wr_ready, 1);
      chk_int("rst done", commit_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk_flat("post-rst taps", taps_flat, pack(imp));
      chk_int("post-rst tap18", tap_of(taps_flat, 18), 8191);
      chk_int("post-rst ready", wr_ready, 1);
      chk_int("post-rst done", commit_done, 0);
      chk_int("post-rst err", addr_err, 0);
      chk_int("post-rst count", wr_count, 0);
      chk_flat("sym post-rst taps", s_taps_flat, pack(imp));

      // ---------------- symmetric instance ----------------
      s_m = imp;
      s_wr_valid = 1'b1; s_wr_addr = 6'd3; s_wr_data = 14'sd120;
      tick();
      s_wr_valid = 1'b0;
      chk_int("sym count", s_wr_count, 1);
      s_commit = 1'b1;
      tick();
      s_commit = 1'b0;
      tick();
      s_m[3] = 120; s_m[33] = 120;
      chk_int("sym done", s_commit_done, 1);
      chk_flat("sym mirror taps", s_taps_flat, pack(s_m));
      s_wr_valid = 1'b1; s_wr_addr = 6'd19; s_wr_data = 14'sd55;
      tick();
      chk_int("sym addr19 err", s_addr_err, 1);
      s_wr_addr = 6'd18; s_wr_data = -14'sd7;
      tick();
      s_wr_valid = 1'b0;
      chk_int("sym centre err", s_addr_err, 0);
      s_commit = 1'b1;
      tick();
      s_commit = 1'b0;
      tick();
      s_m[18] = -7;
      chk_flat("sym centre taps", s_taps_flat, pack(s_m));

      // ---------------- full load and commit ----------------
      for (int k = 0; k < TN; k++) begin
         wr_valid = 1'b1; wr_addr = AW'(k); wr_data = WL'(cf[k]);
         tick();
      end
      wr_valid = 1'b0;
      chk_int("load count", wr_count, 37);
      chk_flat("load taps held", taps_flat, pack(imp));
      commit = 1'b1;
      tick();
      commit = 1'b0;
      chk_int("swap ready", wr_ready, 0);
      chk_int("swap done", commit_done, 0);
      chk_flat("swap taps held", taps_flat, pack(imp));
      tick();
      chk_flat("commit taps", taps_flat, pack(cf));
      chk_int("commit done", commit_done, 1);
      chk_int("commit count", wr_count, 0);
      tick();
      chk_int("commit done drop", commit_done, 0);
      act_m = cf;

      // ---------------- uncommitted write ----------------
      wr_valid = 1'b1; wr_addr = 6'd5; wr_data = -14'sd166;
      tick();
      wr_valid = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk_flat("no-commit taps", taps_flat, pack(act_m));

      // ---------------- vector table ----------------
      for (int i = 0; i < 13; i++) begin
         wr_valid = 1'(tbl[i].valid);
         wr_addr  = AW'(tbl[i].addr);
         wr_data  = WL'(tbl[i].data);
         commit   = 1'(tbl[i].commit);
         tick();
         chk_int($sformatf("v%0d ready", i), wr_ready, tbl[i].ready);
         chk_int($sformatf("v%0d err", i), addr_err, tbl[i].err);
         chk_int($sformatf("v%0d done", i), commit_done, tbl[i].done);
         chk_int($sformatf("v%0d count", i), wr_count, tbl[i].count);
         chk_int($sformatf("v%0d tap%0d", i, tbl[i].tap),
                 tap_of(taps_flat, tbl[i].tap), tbl[i].tap_val);
      end
      wr_valid = 1'b0; commit = 1'b0;
      act_m[5] = -166; act_m[36] = -8192;
      chk_flat("table taps", taps_flat, pack(act_m));
      found = 0;
      for (int k = 0; k < TN; k++) begin
         if (tap_of(taps_flat, k) == 123) found++;
      end
      chk_int("no tap 123", found, 0);

      // ---------------- count saturation ----------------
      for (int i = 0; i < 130; i++) begin
         wr_valid = 1'b1; wr_addr = 6'd40; wr_data = 14'sd99;
         tick();
      end
      wr_valid = 1'b0;
      chk_int("sat count", wr_count, 127);
      chk_int("sat err", addr_err, 1);
      chk_int("sat ready", wr_ready, 1);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      tick();
      chk_int("sat clear count", wr_count, 0);
      chk_int("sat commit done", commit_done, 1);
      chk_flat("sat taps", taps_flat, pack(act_m));

      // ---------------- write+commit, held write during SWAP ----------------
      wr_valid = 1'b1; wr_addr = 6'd7; wr_data = 14'sd321; commit = 1'b1;
      tick();
      commit = 1'b0;
      chk_int("wc ready", wr_ready, 0);
      chk_int("wc count", wr_count, 1);
      wr_addr = 6'd8; wr_data = -14'sd555;
      tick();
      chk_int("wc done", commit_done, 1);
      chk_int("wc ready back", wr_ready, 1);
      chk_int("wc count clr", wr_count, 0);
      chk_int("wc tap7", tap_of(taps_flat, 7), 321);
      chk_int("wc tap8 held", tap_of(taps_flat, 8), 200);
      tick();
      wr_valid = 1'b0;
      chk_int("held accepted count", wr_count, 1);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      tick();
      act_m[7] = 321; act_m[8] = -555;
      chk_flat("held taps", taps_flat, pack(act_m));

      // ---------------- reset during SWAP ----------------
      commit = 1'b1;
      tick();
      commit = 1'b0;
      chk_int("pre-rst swap ready", wr_ready, 0);
      rst_n = 1'b0;
      #1;
      chk_flat("async rst taps", taps_flat, pack(imp));
      chk_int("async rst done", commit_done, 0);
      chk_int("async rst ready", wr_ready, 1);
      tick();
      chk_int("rst hold done", commit_done, 0);
      #3;
      rst_n = 1'b1;
      tick();
      chk_int("rst release done", commit_done, 0);
      chk_int("rst release count", wr_count, 0);
      chk_flat("rst release taps", taps_flat, pack(imp));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
